add_dispatcher: RTL and testbench
=================================

ADD_DISPATCHER -- requirements
Module: add_dispatcher

Interface
REQ-001 Parameter W, 16: operand and sum width in bits; matches the serial adder datapath.
REQ-002 Parameter DEPTH, 4: operand FIFO depth in entries; must be a power of two and at least 2.
REQ-003 Parameter TMO, 63: maximum number of cycles spent waiting on the adder before a timeout.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  operand pair offered.
REQ-007 in_a, in_b  in  W each  operands.
REQ-008 in_ready  out  1  FIFO can accept an entry (not full).
REQ-009 add_start  out  1  start pulse to the serial adder controller.
REQ-010 add_a, add_b  out  W each  operands to the adder A/B load inputs.
REQ-011 add_done  in  1  adder idle/done level (high while the adder sits in IDLE).
REQ-012 add_sum  in  W  adder result register R.
REQ-013 add_cout  in  1  adder final carry (D flip-flop).
REQ-014 res_valid  out  1  result held in the output slot.
REQ-015 res_sum  out  W  sum.
REQ-016 res_cout  out  1  carry out.
REQ-017 res_ready  in  1  consumer accepts the result.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 Push: in_valid&in_ready writes {in_a,in_b} into the FIFO; the entry is visible at head the next cycle.
REQ-020 in_ready=0 when the FIFO is full; a push while full cannot occur, and the FIFO ignores in_valid at that point.
REQ-021 The FSM has states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and CAPTURE.
REQ-022 IDLE->LAUNCH when FIFO not empty & res_valid=0 & add_done=1; otherwise remain in IDLE.
REQ-023 LAUNCH: add_start=1 for exactly one cycle; pop the FIFO head into the op registers feeding add_a/add_b; go to WAIT_BUSY.
REQ-024 add_a/add_b hold their values unchanged from the cycle after LAUNCH until the next LAUNCH (the adder loads them two cycles after start).
REQ-025 WAIT_BUSY: add_start=0; on add_done=0 go to WAIT_DONE.
REQ-026 WAIT_DONE: on add_done=1 go to CAPTURE.
REQ-027 CAPTURE: register add_sum/add_cout into res_sum/res_cout, set res_valid=1 the next cycle, go to IDLE.
REQ-028 res_valid&res_ready clears res_valid the next cycle; res_sum/res_cout hold while res_valid=1.
REQ-029 No new launch while res_valid=1; a result consumed in cycle t allows a launch decision in cycle t+1.
REQ-030 The watchdog counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY/WAIT_DONE; when it reaches TMO the job is dropped, err is set to 1, and the FSM returns to IDLE with no result produced.
REQ-031 err stays set until rst; dispatching continues after a timeout.
REQ-032 Minimum launch-to-res_valid latency with the standard W=16 adder is 21 cycles.

Reset
REQ-033 While rst is asserted: FSM=IDLE, FIFO empty, in_ready=1, add_start=0, add_a=add_b=0, res_valid=0, res_sum=0, res_cout=0, err=0, watchdog=0.
REQ-034 Reset asserted mid-job discards the job, all FIFO contents and any pending result; no partial state survives.

Structure
REQ-035 The shared package holds the FSM state encoding (3-bit) and the defaults for W, DEPTH and TMO.
REQ-036 The FIFO is one sub-module, op_fifo (storage plus read/write pointers with an extra wrap bit, full/empty flags); the FSM and result slot live in add_dispatcher.

Verification
REQ-037 Scenario A: push A=0x1234, B=0x4321 with the adder behavioural model -> single add_start pulse; res_valid=1 with res_sum=0x5555, res_cout=0.
REQ-038 Scenario B: push 0xFFFF+0x0001 -> res_sum=0x0000, res_cout=1.
REQ-039 Scenario C: res_ready=0, push 5 pairs back-to-back -> 1 result held, 4 entries in the FIFO, in_ready=0 on the 5th offer (no further add_start); then release res_ready -> results emerge in push order.
REQ-040 Scenario D: adder model holds add_done=1 (never goes busy) -> err=1 exactly TMO cycles after entering WAIT_BUSY; the next queued job still launches.
REQ-041 Scenario E: rst pulse during WAIT_DONE -> all outputs at their reset values; a subsequent push/launch completes with the correct sum.

Source files
------------

// File: rtl/add_dispatcher_pkg.sv
// Shared definitions for the add dispatcher: FSM state encoding and
// default sizing for the datapath, operand FIFO and adder watchdog.
package add_dispatcher_pkg;

    localparam int W_DEF     = 16;
    localparam int DEPTH_DEF = 4;
    localparam int TMO_DEF   = 63;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_CAPTURE   = 3'd4
    } state_t;

endpackage

// File: rtl/add_dispatcher_op_fifo.sv
// Operand FIFO: power-of-two storage with read/write pointers that carry an
// extra wrap bit, so full and empty are told apart without a separate counter.
module op_fifo
    import add_dispatcher_pkg::*;
#(
    parameter int W     = 2 * W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // A push while full is dropped here as well, independent of the caller.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/add_dispatcher.sv
// Add dispatcher: queues operand pairs, launches them one at a time on an
// external serial adder, guards each job with a watchdog, and holds the
// result in a single-entry output slot until the consumer takes it.
module add_dispatcher
    import add_dispatcher_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         in_ready,
    output logic         add_start,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic         add_done,
    input  logic [W-1:0] add_sum,
    input  logic         add_cout,
    output logic         res_valid,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
    input  logic         res_ready,
    output logic         err
);

    localparam int              WD_W    = $clog2(TMO + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO - 1);

    state_t          state;
    logic [WD_W-1:0] wdog;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [2*W-1:0]  head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    // The head is consumed in the same cycle the start pulse is issued.
    assign pop      = (state == S_LAUNCH);
    assign add_a    = op_a;
    assign add_b    = op_b;

    op_fifo #(
        .W     (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_a, in_b}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Dispatch FSM with watchdog, result slot and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            add_start <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            wdog      <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (res_valid && res_ready)
                res_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Only launch when the slot is free and the adder is idle.
                    if (!empty && !res_valid && add_done) begin
                        state     <= S_LAUNCH;
                        add_start <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    add_start <= 1'b0;
                    op_a      <= head[2*W-1:W];
                    op_b      <= head[W-1:0];
                    wdog      <= '0;
                    state     <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    wdog <= wdog + 1'b1;
                    if (wdog == WD_LAST) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else if (!add_done) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    wdog <= wdog + 1'b1;
                    if (wdog == WD_LAST) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else if (add_done) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    res_sum   <= add_sum;
                    res_cout  <= add_cout;
                    res_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_dispatcher.sv
// Bench for add_dispatcher: behavioural serial adder plus a queue-based
// model of expected sums, driven through directed and randomized steps.
module tb_add_dispatcher;

    localparam int W   = 16;
    localparam int TMO = 63;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_ready;
    logic          add_start;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_done;
    logic [W-1:0]  add_sum;
    logic          add_cout;
    logic          res_valid;
    logic [W-1:0]  res_sum;
    logic          res_cout;
    logic          res_ready;
    logic          err;

    int            total = 0;
    int            bad   = 0;
    int            starts = 0;
    bit            stuck = 0;
    logic [W:0]    exp_q[$];

    add_dispatcher #(.W(W), .DEPTH(4), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_done  (add_done),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_ready (res_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural serial adder: busy for W+2 cycles after start, loads its
    // operands two cycles after the start pulse, ignores start when stuck.
    int         acnt;
    logic [W-1:0] la;
    logic [W-1:0] lb;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            add_done <= 1'b1;
            acnt     <= 0;
            add_sum  <= '0;
            add_cout <= 1'b0;
            la       <= '0;
            lb       <= '0;
        end else if (acnt == 0) begin
            if (add_start && !stuck) begin
                add_done <= 1'b0;
                acnt     <= W + 2;
            end
        end else begin
            acnt <= acnt - 1;
            if (acnt == W + 1) begin
                la <= add_a;
                lb <= add_b;
            end
            if (acnt == 1) begin
                {add_cout, add_sum} <= {1'b0, la} + {1'b0, lb};
                add_done <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (add_start)
            starts <= starts + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one pair and hold it until accepted; record its sum if kept.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
        int n;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400)
            chk("push_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        if (keep)
            exp_q.push_back({1'b0, a} + {1'b0, b});
    endtask

    // Wait for a result, compare against the model queue, then consume it.
    task automatic get_result(input string tag);
        int n;
        logic [W:0] e;
        n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        if (res_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk({tag, "_sum"}, 32'(res_sum), 32'(e[W-1:0]));
            chk({tag, "_cout"}, 32'(res_cout), 32'(e[W]));
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk({tag, "_clear"}, 32'(res_valid), 32'd0);
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!add_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(add_start), 32'd1);
    endtask

    initial begin
        int s0;
        int n;
        bit hold_bad;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_add_start", 32'(add_start), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // A: basic sum, single start pulse, operand hold, latency
        s0 = starts;
        push(16'h1234, 16'h4321, 1'b1);
        wait_start();
        n = 0;
        hold_bad = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
            if (add_a !== 16'h1234 || add_b !== 16'h4321)
                hold_bad = 1;
        end
        chk("A_latency", 32'(n), 32'd21);
        chk("A_op_hold", 32'(hold_bad), 32'd0);
        get_result("A");
        chk("A_one_start", 32'(starts - s0), 32'd1);

        // B: carry out
        push(16'hFFFF, 16'h0001, 1'b1);
        get_result("B");

        // Randomized batches
        for (int r = 0; r < 6; r++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int j = 0; j < nb; j++) begin
                ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
                rb = W'($urandom);
                push(ra, rb, 1'b1);
            end
            for (int j = 0; j < nb; j++)
                get_result("RND");
        end

        // C: backpressure fills the FIFO, results drain in order
        s0 = starts;
        for (int j = 0; j < 5; j++)
            push(16'h1000 * 16'(j + 1), 16'h0101 * 16'(j + 1), 1'b1);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("C_full", 32'(in_ready), 32'd0);
        in_a = 16'hDEAD;
        in_b = 16'hBEEF;
        in_valid = 1'b1;
        repeat (20) @(negedge clk);
        chk("C_still_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        chk("C_no_extra_start", 32'(starts - s0), 32'd1);
        chk("C_hold_sum", 32'(res_sum), 32'h1101);
        for (int j = 0; j < 5; j++)
            get_result("C");
        chk("C_drained", 32'(in_ready), 32'd1);

        // D: adder never goes busy -> timeout, then next job proceeds
        chk("D_err_pre", 32'(err), 32'd0);
        stuck = 1;
        push(16'h0F0F, 16'h0101, 1'b0);
        push(16'h2222, 16'h3333, 1'b1);
        wait_start();
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        stuck = 0;
        chk("D_err_time", 32'(n), 32'(TMO + 1));
        chk("D_no_result", 32'(res_valid), 32'd0);
        get_result("D");
        chk("D_err_sticky", 32'(err), 32'd1);

        // E: reset during WAIT_DONE
        push(16'h5A5A, 16'h0A0A, 1'b1);
        wait_start();
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("E_in_ready", 32'(in_ready), 32'd1);
        chk("E_add_start", 32'(add_start), 32'd0);
        chk("E_add_ab", 32'({add_a, add_b}), 32'd0);
        chk("E_res_valid", 32'(res_valid), 32'd0);
        chk("E_res", 32'({res_cout, res_sum}), 32'd0);
        chk("E_err", 32'(err), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (res_valid || add_start)
                n++;
        end
        chk("E_nothing_survives", 32'(n), 32'd0);
        push(16'h8001, 16'h8003, 1'b1);
        get_result("E");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
